// File: rtl/register_pkg.sv
// Shared defaults and helpers for the register pipeline.
// Optional parity output is enabled by defining REGISTER_PARITY_EN.
package register_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_DEPTH   = 1;
    localparam logic [63:0] DEFAULT_RST_VAL = '0;
    localparam int unsigned MAX_DEPTH       = 8;
    localparam int unsigned MAX_WIDTH       = 64;

    // Even parity: 1 when an odd number of bits are set.
    function automatic logic parity64(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/register_stage.sv
// One WIDTH-bit pipeline flop with asynchronous active-low reset to RST_VAL.
module register_stage
    import register_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/register.sv
// DEPTH-stage data pipeline with asynchronous active-low reset.
// Define REGISTER_PARITY_EN to add parity_out (XOR of all data_out bits).
module register
    import register_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter logic [63:0] RST_VAL = DEFAULT_RST_VAL,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
`ifdef REGISTER_PARITY_EN
    output logic             parity_out,
`endif
    output logic [WIDTH-1:0] data_out
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "register: WIDTH=%0d outside legal range 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "register: DEPTH=%0d outside legal range 1..%0d", DEPTH, MAX_DEPTH);
    end

    localparam logic [WIDTH-1:0] RST_TRUNC = RST_VAL[WIDTH-1:0];

    // stage_q[0] is the raw input; stage_q[DEPTH] is the last flop.
    logic [WIDTH-1:0] stage_q [DEPTH+1];

    assign stage_q[0] = data_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        register_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_TRUNC)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d_i (stage_q[i]),
            .q_o (stage_q[i+1])
        );
    end

    assign data_out = stage_q[DEPTH];

`ifdef REGISTER_PARITY_EN
    assign parity_out = parity64(64'(data_out));
`endif

endmodule

// File: tb/tb_register.sv
// Randomized bench for register: DEPTH=1 default instance and DEPTH=3 / RST_VAL=A5A5A5A5 instance.
// Parity checks are compiled in when REGISTER_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_register;

    localparam logic [31:0] RV3 = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [31:0] out1;
    logic [31:0] out3;
`ifdef REGISTER_PARITY_EN
    logic        par1;
    logic        par3;
`endif

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    register u_d1 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
`ifdef REGISTER_PARITY_EN
        .parity_out (par1),
`endif
        .data_out   (out1)
    );

    register #(
        .WIDTH   (32),
        .RST_VAL (64'hA5A5A5A5),
        .DEPTH   (3)
    ) u_d3 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
`ifdef REGISTER_PARITY_EN
        .parity_out (par3),
`endif
        .data_out   (out3)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference model: history of every value accepted since the last reset.
    logic [31:0] hist[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
        end else begin
            hist.push_back(data_in);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    function automatic logic [31:0] expect_out(input int unsigned depth, input logic [31:0] rv);
        if (hist.size() < depth) return rv;
        return hist[hist.size() - depth];
    endfunction

    function automatic logic expect_par(input logic [31:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    task automatic test_reset();
        rst     = 1'b0;
        data_in = '0;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (out1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_d1 t=%0t: got %h want %h", $time, out1, 32'h0);
            end
            vectors++;
            if (out3 !== RV3) begin
                errors++;
                $display("FAIL reset_d3 t=%0t: got %h want %h", $time, out3, RV3);
            end
        end
    endtask

    task automatic test_count();
        for (int unsigned i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b1;
            vectors++;
            if (out1 !== expect_out(1, 32'h0)) begin
                errors++;
                $display("FAIL count_d1 step=%0d: got %h want %h", i, out1, expect_out(1, 32'h0));
            end
            vectors++;
            if (out3 !== expect_out(3, RV3)) begin
                errors++;
                $display("FAIL count_d3 step=%0d: got %h want %h", i, out3, expect_out(3, RV3));
            end
            if (i < 10) data_in = i;
        end
        vectors++;
        if (out1 !== 32'd9) begin
            errors++;
            $display("FAIL count_end: got %h want %h", out1, 32'd9);
        end
    endtask

    task automatic test_wide();
        logic [31:0] pats [4];
        pats[0] = 32'hFFFF_FFFF;
        pats[1] = 32'h8000_0001;
        pats[2] = $urandom;
        pats[3] = $urandom;
        for (int unsigned i = 0; i < 4; i++) begin
            data_in = pats[i];
            @(negedge clk);
            vectors++;
            if (out1 !== pats[i]) begin
                errors++;
                $display("FAIL wide_d1 idx=%0d: got %h want %h", i, out1, pats[i]);
            end
            vectors++;
            if (out3 !== expect_out(3, RV3)) begin
                errors++;
                $display("FAIL wide_d3 idx=%0d: got %h want %h", i, out3, expect_out(3, RV3));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        data_in = 32'd5;
        @(negedge clk);
        vectors++;
        if (out1 !== 32'd5) begin
            errors++;
            $display("FAIL areset_pre: got %h want %h", out1, 32'd5);
        end
        #20 rst = 1'b0;
        data_in = $urandom;
        #1;
        vectors++;
        if (out1 !== 32'h0) begin
            errors++;
            $display("FAIL areset_d1_now: got %h want %h", out1, 32'h0);
        end
        vectors++;
        if (out3 !== RV3) begin
            errors++;
            $display("FAIL areset_d3_now: got %h want %h", out3, RV3);
        end
        // An edge while reset is held must not load anything.
        @(negedge clk);
        vectors++;
        if (out1 !== 32'h0) begin
            errors++;
            $display("FAIL areset_hold: got %h want %h", out1, 32'h0);
        end
        rst = 1'b1;
        v = $urandom;
        data_in = v;
        @(negedge clk);
        vectors++;
        if (out1 !== v) begin
            errors++;
            $display("FAIL areset_resume: got %h want %h", out1, v);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            vectors++;
            if (out3 !== expect_out(3, RV3)) begin
                errors++;
                $display("FAIL areset_d3_fill step=%0d: got %h want %h", i, out3, expect_out(3, RV3));
            end
            data_in = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e3;
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            e1 = expect_out(1, 32'h0);
            e3 = expect_out(3, RV3);
            vectors++;
            if (out1 !== e1) begin
                errors++;
                $display("FAIL rand_d1 cyc=%0d: got %h want %h", i, out1, e1);
            end
            vectors++;
            if (out3 !== e3) begin
                errors++;
                $display("FAIL rand_d3 cyc=%0d: got %h want %h", i, out3, e3);
            end
`ifdef REGISTER_PARITY_EN
            vectors++;
            if (par1 !== expect_par(e1) || par3 !== expect_par(e3)) begin
                errors++;
                $display("FAIL rand_par cyc=%0d: got %b/%b want %b/%b", i, par1, par3,
                         expect_par(e1), expect_par(e3));
            end
`endif
            data_in = $urandom;
            #10;
            vectors++;
            if (out1 !== e1 || out3 !== e3) begin
                errors++;
                $display("FAIL rand_between cyc=%0d: got %h/%h want %h/%h", i, out1, out3, e1, e3);
            end
            if ($urandom_range(39, 0) == 0) begin
                rst = 1'b0;
                #10 rst = 1'b1;
            end
        end
    endtask

`ifdef REGISTER_PARITY_EN
    task automatic test_parity();
        logic [31:0] pats [2];
        logic        want [2];
        pats[0] = 32'h0000_0007;
        want[0] = 1'b1;
        pats[1] = 32'h0000_0003;
        want[1] = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            data_in = pats[i];
            @(negedge clk);
            vectors++;
            if (par1 !== want[i]) begin
                errors++;
                $display("FAIL parity data=%h: got %b want %b", out1, par1, want[i]);
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (par1 !== 1'b0 || par3 !== expect_par(RV3)) begin
            errors++;
            $display("FAIL parity_reset: got %b/%b want %b/%b", par1, par3, 1'b0, expect_par(RV3));
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_wide();
        test_async_reset();
        test_random();
`ifdef REGISTER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
